// File: rtl/adsr_pkg.sv
// Shared phase encoding for the ADSR envelope generator and its level-step datapath.
package adsr_pkg;

    localparam int unsigned PhaseW = 3;

    typedef enum logic [PhaseW-1:0] {
        PhIdle    = 3'd0,
        PhAttack  = 3'd1,
        PhDecay   = 3'd2,
        PhSustain = 3'd3,
        PhRelease = 3'd4
    } adsr_phase_e;

endpackage

// File: rtl/adsr_step.sv
// Combinational level-step datapath: next envelope level and phase-done flag for one tick.
module adsr_step
    import adsr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  adsr_phase_e      phase_i,
    input  logic [WIDTH-1:0] env_i,
    input  logic [WIDTH-1:0] ai_i,
    input  logic [WIDTH-1:0] di_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] ri_i,
    output logic [WIDTH-1:0] env_o,
    output logic             done_o
);

    localparam logic [WIDTH:0] MaxW = {1'b0, {WIDTH{1'b1}}};

    // One extra bit so attack overshoot and the decay floor compare never wrap.
    logic [WIDTH:0] env_w;
    logic [WIDTH:0] sum_a;
    logic [WIDTH:0] s_plus_d;

    assign env_w    = {1'b0, env_i};
    assign sum_a    = env_w + {1'b0, ai_i};
    assign s_plus_d = {1'b0, s_i} + {1'b0, di_i};

    always_comb begin
        env_o  = '0;
        done_o = 1'b0;
        case (phase_i)
            PhAttack: begin
                if (ai_i == '0 || sum_a >= MaxW) begin
                    env_o  = {WIDTH{1'b1}};
                    done_o = 1'b1;
                end else begin
                    env_o = sum_a[WIDTH-1:0];
                end
            end
            PhDecay: begin
                if (di_i == '0 || env_w <= s_plus_d) begin
                    env_o  = s_i;
                    done_o = 1'b1;
                end else begin
                    env_o = env_i - di_i;
                end
            end
            PhSustain: begin
                env_o = s_i;
            end
            PhRelease: begin
                if (ri_i == '0 || env_i <= ri_i) begin
                    env_o  = '0;
                    done_o = 1'b1;
                end else begin
                    env_o = env_i - ri_i;
                end
            end
            default: begin
                env_o  = '0;
                done_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/adsr_gen.sv
// ADSR envelope generator: gate edge detect and phase FSM, level steps gated by a rate tick.
module adsr_gen
    import adsr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              tick_i,
    input  logic              trig_i,
    input  logic              hard_retrig_i,
    input  logic [WIDTH-1:0]  ai_i,
    input  logic [WIDTH-1:0]  di_i,
    input  logic [WIDTH-1:0]  s_i,
    input  logic [WIDTH-1:0]  ri_i,
    output logic [WIDTH-1:0]  envelope_o,
    output logic [PhaseW-1:0] phase_o,
    output logic              active_o
);

    adsr_phase_e      state_q, state_d;
    logic [WIDTH-1:0] env_q, env_d;
    logic             trig_q;
    logic             rise;
    logic [WIDTH-1:0] step_env;
    logic             step_done;

    assign rise = trig_i & ~trig_q;

    adsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .phase_i (state_q),
        .env_i   (env_q),
        .ai_i    (ai_i),
        .di_i    (di_i),
        .s_i     (s_i),
        .ri_i    (ri_i),
        .env_o   (step_env),
        .done_o  (step_done)
    );

    // Gate events take priority; level steps only happen on tick with no gate event.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            PhIdle, PhRelease: begin
                if (rise) begin
                    state_d = PhAttack;
                    env_d   = hard_retrig_i ? '0 : env_q;
                end else if (tick_i) begin
                    env_d = step_env;
                    if (step_done) begin
                        state_d = PhIdle;
                    end
                end
            end
            PhAttack, PhDecay, PhSustain: begin
                if (!trig_i) begin
                    state_d = PhRelease;
                end else if (tick_i) begin
                    env_d = step_env;
                    if (step_done) begin
                        state_d = (state_q == PhAttack) ? PhDecay : PhSustain;
                    end
                end
            end
            default: begin
                state_d = PhIdle;
                env_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= PhIdle;
            env_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            trig_q  <= trig_i;
        end
    end

    assign envelope_o = env_q;
    assign phase_o    = state_q;
    assign active_o   = (state_q != PhIdle);

endmodule

// File: tb/tb_adsr_gen.sv
// Directed scoreboard bench for adsr_gen at WIDTH=8 and WIDTH=12.
module tb_adsr_gen;

    localparam logic [2:0] PI = 3'd0;
    localparam logic [2:0] PA = 3'd1;
    localparam logic [2:0] PD = 3'd2;
    localparam logic [2:0] PS = 3'd3;
    localparam logic [2:0] PR = 3'd4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        tick8, trig8, hard8;
    logic [7:0]  ai8, di8, s8, ri8, env8;
    logic [2:0]  ph8;
    logic        act8;

    logic        tick12, trig12, hard12;
    logic [11:0] ai12, di12, s12, ri12, env12;
    logic [2:0]  ph12;
    logic        act12;

    adsr_gen #(
        .WIDTH (8)
    ) u_dut8 (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .tick_i        (tick8),
        .trig_i        (trig8),
        .hard_retrig_i (hard8),
        .ai_i          (ai8),
        .di_i          (di8),
        .s_i           (s8),
        .ri_i          (ri8),
        .envelope_o    (env8),
        .phase_o       (ph8),
        .active_o      (act8)
    );

    adsr_gen #(
        .WIDTH (12)
    ) u_dut12 (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .tick_i        (tick12),
        .trig_i        (trig12),
        .hard_retrig_i (hard12),
        .ai_i          (ai12),
        .di_i          (di12),
        .s_i           (s12),
        .ri_i          (ri12),
        .envelope_o    (env12),
        .phase_o       (ph12),
        .active_o      (act12)
    );

    typedef struct {
        bit          sel;
        logic [11:0] env;
        logic [2:0]  ph;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   next_id = 0;

    task automatic cmp(input bit sel, input logic [11:0] e_env, input logic [2:0] e_ph,
                       input int id);
        logic [11:0] a_env;
        logic [2:0]  a_ph;
        logic        a_act;
        logic        e_act;
        if (sel) begin
            a_env = env12;
            a_ph  = ph12;
            a_act = act12;
        end else begin
            a_env = {4'h0, env8};
            a_ph  = ph8;
            a_act = act8;
        end
        e_act = (e_ph != PI);
        n_vec++;
        if (a_env !== e_env || a_ph !== e_ph || a_act !== e_act) begin
            n_bad++;
            $display("FAIL vec%0d dut%0d: got env=%h phase=%0d active=%b, want env=%h phase=%0d active=%b",
                     id, sel ? 12 : 8, a_env, a_ph, a_act, e_env, e_ph, e_act);
        end
    endtask

    task automatic push(input bit sel, input logic [11:0] env, input logic [2:0] ph);
        exp_t e;
        e.sel = sel;
        e.env = env;
        e.ph  = ph;
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic tk, input logic tg, input logic hr);
        @(negedge clk);
        tick8 = tk;
        trig8 = tg;
        hard8 = hr;
    endtask

    // Drive one cycle of dut8 inputs and queue the state expected after the next edge.
    task automatic run8(input logic tk, input logic tg, input logic hr,
                        input logic [7:0] env, input logic [2:0] ph);
        cyc(tk, tg, hr);
        push(1'b0, {4'h0, env}, ph);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                cmp(e.sel, e.env, e.ph, e.id);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin : stim
        rstn   = 1'b0;
        tick8  = 1'b1; trig8 = 1'b0; hard8 = 1'b0;
        ai8    = 8'h40; di8 = 8'h10; s8 = 8'h80; ri8 = 8'h20;
        tick12 = 1'b1; trig12 = 1'b0; hard12 = 1'b0;
        ai12   = 12'h800; di12 = 12'h100; s12 = 12'h800; ri12 = 12'h100;
        #3;
        cmp(1'b0, 12'h000, PI, -1);
        cmp(1'b1, 12'h000, PI, -2);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Full attack / decay to sustain
        run8(1, 1, 0, 8'h00, PA);
        run8(1, 1, 0, 8'h40, PA);
        run8(1, 1, 0, 8'h80, PA);
        run8(1, 1, 0, 8'hC0, PA);
        run8(1, 1, 0, 8'hFF, PD);
        run8(1, 1, 0, 8'hEF, PD);
        run8(1, 1, 0, 8'hDF, PD);
        run8(1, 1, 0, 8'hCF, PD);
        run8(1, 1, 0, 8'hBF, PD);
        run8(1, 1, 0, 8'hAF, PD);
        run8(1, 1, 0, 8'h9F, PD);
        run8(1, 1, 0, 8'h8F, PD);
        run8(1, 1, 0, 8'h80, PS);
        run8(1, 1, 0, 8'h80, PS);

        // Release to idle
        run8(1, 0, 0, 8'h80, PR);
        run8(1, 0, 0, 8'h60, PR);
        run8(1, 0, 0, 8'h40, PR);
        run8(1, 0, 0, 8'h20, PR);
        run8(1, 0, 0, 8'h00, PI);

        // Zero rates are instant
        @(negedge clk);
        ai8 = 8'h00; di8 = 8'h00; ri8 = 8'h00; s8 = 8'h33;
        run8(1, 1, 0, 8'h00, PA);
        run8(1, 1, 0, 8'hFF, PD);
        run8(1, 1, 0, 8'h33, PS);
        run8(1, 0, 0, 8'h33, PR);
        run8(1, 0, 0, 8'h00, PI);

        // Retrigger from release: legato then hard
        @(negedge clk);
        ai8 = 8'h40; di8 = 8'h10; ri8 = 8'h20; s8 = 8'h80;
        run8(1, 1, 0, 8'h00, PA);
        run8(1, 1, 0, 8'h40, PA);
        run8(1, 1, 0, 8'h80, PA);
        run8(1, 0, 0, 8'h80, PR);
        run8(1, 0, 0, 8'h60, PR);
        run8(1, 1, 0, 8'h60, PA);
        run8(1, 1, 0, 8'hA0, PA);
        run8(1, 0, 0, 8'hA0, PR);
        run8(1, 0, 0, 8'h80, PR);
        run8(1, 0, 0, 8'h60, PR);
        run8(1, 1, 1, 8'h00, PA);
        run8(1, 1, 0, 8'h40, PA);
        run8(1, 0, 0, 8'h40, PR);
        run8(1, 0, 0, 8'h20, PR);
        run8(1, 0, 0, 8'h00, PI);

        // Sparse tick during attack; gate fall still acts without tick
        run8(0, 1, 0, 8'h00, PA);
        run8(1, 1, 0, 8'h40, PA);
        run8(0, 1, 0, 8'h40, PA);
        run8(0, 1, 0, 8'h40, PA);
        run8(0, 1, 0, 8'h40, PA);
        run8(1, 1, 0, 8'h80, PA);
        run8(0, 0, 0, 8'h80, PR);
        run8(0, 0, 0, 8'h80, PR);
        run8(1, 0, 0, 8'h60, PR);

        // Into decay, then async reset mid-decay
        run8(1, 0, 0, 8'h40, PR);
        run8(1, 0, 0, 8'h20, PR);
        run8(1, 0, 0, 8'h00, PI);
        run8(1, 1, 0, 8'h00, PA);
        run8(1, 1, 0, 8'h40, PA);
        run8(1, 1, 0, 8'h80, PA);
        run8(1, 1, 0, 8'hC0, PA);
        run8(1, 1, 0, 8'hFF, PD);
        run8(1, 1, 0, 8'hEF, PD);
        @(posedge clk);
        #2;
        rstn   = 1'b0;
        trig12 = 1'b1;
        #1;
        cmp(1'b0, 12'h000, PI, -3);
        cmp(1'b1, 12'h000, PI, -4);
        @(posedge clk);

        // Gate held across reset release is a rising edge on the first clock
        @(negedge clk);
        rstn = 1'b1;
        push(1'b0, 12'h000, PA);
        push(1'b1, 12'h000, PA);
        cyc(1, 1, 0);
        push(1'b0, 12'h040, PA);
        push(1'b1, 12'h800, PA);
        cyc(1, 1, 0);
        push(1'b0, 12'h080, PA);
        push(1'b1, 12'hFFF, PD);

        @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
